// File: rtl/debounce_pkg.sv
// Shared defaults and helpers for the debounce bank.
package debounce_pkg;

   localparam int unsigned DEF_N_CH            = 8;
   localparam int unsigned DEF_SYNC_STAGES     = 2;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 256;
   localparam int unsigned DEF_STEP_CNT_W      = 16;

   // Width of a stability counter able to hold 0..cycles.
   function automatic int unsigned cnt_width(input int unsigned cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: synchroniser, stability counter, debounced level and edge pulses.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter logic        INIT            = 1'b1,
   parameter bit          ACTIVE_LOW      = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic level_nxt_c,
   output logic press_nxt_c
);

   localparam int unsigned      CNT_W      = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic             ACTIVE_LVL = ACTIVE_LOW ? 1'b0 : 1'b1;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   press_q, press_d;
   logic                   release_q, release_d;
   logic                   sync_s;

   // Shift the pin through the synchroniser and debounce the last stage.
   always_comb begin
      sync_d    = {sync_q[SYNC_STAGES-2:0], raw_i};
      sync_s    = sync_q[SYNC_STAGES-1];
      cnt_d     = '0;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (sync_s != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d   = sync_s;
            press_d   = (sync_s == ACTIVE_LVL);
            release_d = (sync_s != ACTIVE_LVL);
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Channel state registers; reset loads the pull-up level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= {SYNC_STAGES{INIT}};
         cnt_q     <= '0;
         level_q   <= INIT;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign level_o     = level_q;
   assign press_o     = press_q;
   assign release_o   = release_q;
   assign level_nxt_c = level_d;
   assign press_nxt_c = press_d;

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel input conditioner with an integrated single-step controller.
module debounce_bank
   import debounce_pkg::*;
#(
   parameter int unsigned     N_CH            = DEF_N_CH,
   parameter int unsigned     SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int unsigned     DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter logic [N_CH-1:0] INIT_LEVEL      = '1,
   parameter bit              ACTIVE_LOW      = 1'b1,
   parameter int unsigned     RUN_CH          = 7,
   parameter int unsigned     STEP_CH         = 0,
   parameter int unsigned     STEP_CNT_W      = DEF_STEP_CNT_W
) (
   input  logic                  CLK_CPU,
   input  logic                  resetn,
   input  logic [N_CH-1:0]       raw_i,
   output logic [N_CH-1:0]       level_o,
   output logic [N_CH-1:0]       press_o,
   output logic [N_CH-1:0]       release_o,
   output logic                  stall_o,
   output logic [STEP_CNT_W-1:0] step_count_o
);

   // Configuration sanity: run select and step button must be distinct, existing channels.
   if (RUN_CH == STEP_CH) begin : g_err_same_ch
      $error("debounce_bank: RUN_CH and STEP_CH must differ");
   end
   if (RUN_CH >= N_CH || STEP_CH >= N_CH) begin : g_err_ch_range
      $error("debounce_bank: RUN_CH/STEP_CH out of range");
   end
   if (SYNC_STAGES < 2) begin : g_err_sync
      $error("debounce_bank: SYNC_STAGES must be >= 2");
   end
   if (DEBOUNCE_CYCLES < 1) begin : g_err_deb
      $error("debounce_bank: DEBOUNCE_CYCLES must be >= 1");
   end

   logic [N_CH-1:0]       level_nxt;
   logic [N_CH-1:0]       press_nxt;
   logic [STEP_CNT_W-1:0] step_cnt_q, step_cnt_d;

   // One conditioner per input pin.
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_channel #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .INIT            (INIT_LEVEL[i]),
         .ACTIVE_LOW      (ACTIVE_LOW)
      ) u_ch (
         .clk         (CLK_CPU),
         .rst_n       (resetn),
         .raw_i       (raw_i[i]),
         .level_o     (level_o[i]),
         .press_o     (press_o[i]),
         .release_o   (release_o[i]),
         .level_nxt_c (level_nxt[i]),
         .press_nxt_c (press_nxt[i])
      );
   end

   // Count a step on the edge that raises the step press while the post-edge mode is step.
   always_comb begin
      step_cnt_d = step_cnt_q;
      if (!level_nxt[RUN_CH] && press_nxt[STEP_CH]) begin
         step_cnt_d = step_cnt_q + STEP_CNT_W'(1);
      end
   end

   // Step counter register.
   always_ff @(posedge CLK_CPU or negedge resetn) begin
      if (!resetn) begin
         step_cnt_q <= '0;
      end else begin
         step_cnt_q <= step_cnt_d;
      end
   end

   // Free run holds stall low; step mode releases it only during a step press pulse.
   assign stall_o      = level_o[RUN_CH] ? 1'b0 : !press_o[STEP_CH];
   assign step_count_o = step_cnt_q;

endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
- Parametrised, multi-channel input conditioner for slow board inputs (DIP switches, push buttons, mode straps).
- Each channel is synchronised into the CPU clock domain, debounced with a per-channel stability counter, and edge-decoded into one-cycle press and release pulses.
- An integrated single-step controller turns one channel into a run/step mode select and another into a step button, producing the CPU stall signal and a count of granted steps.
- Sits between the board top-level pin buffers and the CPU core.

Parameters:
- N_CH, 8, number of input channels (>=1)
- SYNC_STAGES, 2, synchroniser flop depth (>=2)
- DEBOUNCE_CYCLES, 256, consecutive differing samples required to accept a new level (>=1)
- INIT_LEVEL, all-ones [N_CH], reset value of synchroniser and debounced level per channel (pull-ups)
- ACTIVE_LOW, 1, 1: press = 1->0 transition of level; 0: press = 0->1
- RUN_CH, 7, channel index used as run-mode select; level 1 = free run
- STEP_CH, 0, channel index used as step button
- STEP_CNT_W, 16, width of step counter

Ports:
- CLK_CPU  in  1  CPU clock, the only clock
- resetn  in  1  reset; asynchronous assert, active-low
- raw_i  in  N_CH  unsynchronised pin levels
- level_o  out  N_CH  debounced level
- press_o  out  N_CH  one-cycle press pulse
- release_o  out  N_CH  one-cycle release pulse
- stall_o  out  1  CPU stall request
- step_count_o  out  STEP_CNT_W  number of granted single steps, wraps

Behaviour:
- Reset (resetn low, asynchronous):
  - sync flops and level_o = INIT_LEVEL; counters = 0; press_o = release_o = 0; step_count_o = 0.
  - stall_o follows the combinational rule below from reset state: 0 when INIT_LEVEL[RUN_CH] = 1.
- Synchroniser: SYNC_STAGES flops per channel; sync_s = last stage.
- Counter, per channel, width CNT_W = $clog2(DEBOUNCE_CYCLES+1):
  - sync_s == level_o: cnt <= 0.
  - sync_s != level_o and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - sync_s != level_o and cnt == DEBOUNCE_CYCLES-1: level_o <= sync_s, cnt <= 0.
- Latency: a raw change held stable appears on level_o at clock edge SYNC_STAGES+DEBOUNCE_CYCLES, counting the first edge that samples it as edge 1.
- Glitch rejection: any return to the old level before acceptance clears cnt and leaves level_o unchanged, with no pulses.
- Pulses are registered and asserted on the same edge that level_o changes, high for exactly one cycle.
  - press_o[i] on an active-going change: 1->0 if ACTIVE_LOW, else 0->1. release_o[i] on the opposite change.
  - press_o[i] and release_o[i] are never high together.
- Step controller (combinational from registered state):
  - level_o[RUN_CH] == 1: stall_o = 0 (free run).
  - level_o[RUN_CH] == 0: stall_o = !press_o[STEP_CH]; stall is released for exactly one cycle per step press.
  - step_count_o increments on each edge where level_o[RUN_CH]==0 and press_o[STEP_CH]==1; wraps max->0.
  - A mode change and a step press in the same cycle count as a step if the post-edge run level is 0.
- Reset mid-operation clears counters immediately; no pulse is generated for the interrupted change. After reset release, a raw level differing from INIT_LEVEL is debounced normally and does produce a pulse.
- RUN_CH == STEP_CH is illegal; flag it with an elaboration-time assertion.

Decomposition:
- Package debounce_pkg:
  - default constants: DEF_SYNC_STAGES, DEF_DEBOUNCE_CYCLES, DEF_STEP_CNT_W
  - function for counter width
- Sub-module debounce_channel: sync + counter + level + press/release for one channel, instantiated N_CH times in a generate loop.
- The step controller stays in debounce_bank.

Test Plan (N_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=8, INIT_LEVEL=4'hF, ACTIVE_LOW=1, RUN_CH=3, STEP_CH=0, STEP_CNT_W=4):
- Reset hold with raw_i=4'h0:
  - During reset: level_o=4'hF, press_o=release_o=0, stall_o=0, step_count_o=0.
  - Release reset, hold raw_i=0: level_o=4'h0 at edge 10, press_o=4'hF for one cycle, step_count_o=1.
- Glitch: from raw_i=4'hF settled, raw_i[1]=0 for 7 cycles then 1 -> level_o stays 4'hF, no pulses. Repeat with 8 cycles low -> level_o[1]=0 at edge 10, press_o=4'h2 for one cycle.
- Single step: raw_i[3]=0 settled (stall_o=1), raw_i[0] low 20 cycles then high:
  - stall_o=0 for exactly one cycle; step_count_o +1.
  - release_o[0] pulses 10 edges after the rising edge; no extra step.
- Free run: raw_i[3]=1 settled, step presses -> stall_o stays 0, step_count_o unchanged.
- Async reset mid-count: drop resetn when channel 2 cnt=5 -> outputs return to reset values immediately (without a clock edge), no pulse ever appears for that change.
- Wrap: 16 step presses in step mode from count 0 -> step_count_o goes 15 then 0.
